// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its cache.
package inst_fetch_pkg;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam int          MEM_DW   = 8;
  localparam int          STALL_W  = 6;
  localparam int          STALL_IF = 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_t;

  // Byte k of the word at base; plain 32-bit add so addresses wrap naturally.
  function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [2:0] k);
    return base + {29'b0, k};
  endfunction

endpackage

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-entry instruction cache: combinational lookup,
// synchronous fill, valid bits cleared by reset.
module inst_cache #(
  parameter int ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr,
  output logic        hit,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam int ENTRIES = 1 << ICACHE_IDX_W;
  localparam int TAG_W   = 30 - ICACHE_IDX_W;

  logic [ENTRIES-1:0]      valid;
  logic [TAG_W-1:0]        tags [ENTRIES];
  logic [31:0]             data [ENTRIES];
  logic [ICACHE_IDX_W-1:0] ridx;
  logic [ICACHE_IDX_W-1:0] widx;
  logic                    unused_low;

  assign ridx       = raddr[ICACHE_IDX_W+1:2];
  assign widx       = waddr[ICACHE_IDX_W+1:2];
  assign hit        = valid[ridx] && (tags[ridx] == raddr[31:ICACHE_IDX_W+2]);
  assign rdata      = data[ridx];
  assign unused_low = ^{raddr[1:0], waddr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx] <= waddr[31:ICACHE_IDX_W+2];
      data[widx] <= wdata;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: cache lookup on pc, byte-serial refill on a miss,
// and the registered IF/ID boundary feeding decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_enable,
  input  logic               mem_busy,
  input  logic [MEM_DW-1:0]  mem_din,
  output logic [31:0]        mem_a,
  output logic               mem_rd,
  output logic               stallreq_if,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid
);

  fetch_state_t state;
  logic [2:0]   issued;
  logic [2:0]   recv;
  logic         pending;
  logic [31:0]  word_buf;

  logic         hit;
  logic [31:0]  cache_rdata;
  logic         cache_we;
  logic         ready;
  logic [31:0]  ready_word;
  logic         capture;
  logic         unused_stall;

  assign unused_stall = ^{stall[STALL_W-1:STALL_IF+1], stall[STALL_IF-1:0]};

  inst_cache #(
    .ICACHE_IDX_W(ICACHE_IDX_W)
  ) u_cache (
    .clk   (clk),
    .rst   (rst),
    .raddr (pc),
    .hit   (hit),
    .rdata (cache_rdata),
    .we    (cache_we),
    .waddr (pc),
    .wdata (word_buf)
  );

  always_comb begin
    mem_rd      = 1'b0;
    mem_a       = '0;
    stallreq_if = 1'b0;
    ready       = 1'b0;
    ready_word  = word_buf;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            ready      = 1'b1;
            ready_word = cache_rdata;
          end else begin
            stallreq_if = 1'b1;
            mem_rd      = !mem_busy;
          end
        end
        FETCH: begin
          stallreq_if = 1'b1;
          mem_rd      = !mem_busy && (issued < 3'd4);
        end
        DONE:    ready = 1'b1;
        default: ready = 1'b0;
      endcase
      if (mem_rd) mem_a = byte_addr(pc, issued);
    end
  end

  // pending marks a read issued last cycle, so mem_din carries its byte now.
  assign capture  = pending && !branch_enable && (state == FETCH);
  assign cache_we = (state == DONE) && !branch_enable && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      issued   <= '0;
      recv     <= '0;
      pending  <= 1'b0;
      word_buf <= '0;
    end else if (branch_enable) begin
      state   <= IDLE;
      issued  <= '0;
      recv    <= '0;
      pending <= 1'b0;
    end else begin
      pending <= mem_rd;
      if (mem_rd) issued <= issued + 3'd1;
      if (capture) begin
        word_buf[{recv[1:0], 3'b000} +: 8] <= mem_din;
        recv <= recv + 3'd1;
      end
      unique case (state)
        IDLE:  if (mem_rd) state <= FETCH;
        FETCH: if (capture && recv == 3'd3) state <= DONE;
        DONE: begin
          state  <= IDLE;
          issued <= '0;
          recv   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A bubble keeps inst_pc; only a flush or reset clears it.
  always_ff @(posedge clk) begin
    if (rst || branch_enable) begin
      inst_valid <= 1'b0;
      inst       <= NOP;
      inst_pc    <= '0;
    end else if (!stall[STALL_IF]) begin
      if (ready) begin
        inst       <= ready_word;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end else begin
        inst_valid <= 1'b0;
        inst       <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: byte-wide memory model plus
// scoreboards of expected memory addresses and expected IF/ID words.
module tb_inst_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  localparam logic [31:0] NOP_W = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        branch_enable;
  logic        mem_busy;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic        stallreq_if;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  int tests;
  int failures;

  logic [31:0] addr_q[$];
  exp_t        exp_q[$];
  logic [31:0] last_inst;
  logic [31:0] last_pc;
  logic        last_valid;

  inst_fetch #(
    .ICACHE_IDX_W(6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .stall         (stall),
    .branch_enable (branch_enable),
    .mem_busy      (mem_busy),
    .mem_din       (mem_din),
    .mem_a         (mem_a),
    .mem_rd        (mem_rd),
    .stallreq_if   (stallreq_if),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h93;
      32'd1:   return 8'h00;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ 8'hA5 ^ {a[11:8], a[3:0]};
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {mem_model(a + 32'd3), mem_model(a + 32'd2), mem_model(a + 32'd1), mem_model(a)};
  endfunction

  // Memory answers one cycle after the address; 8'hEE otherwise so stray captures show.
  always @(posedge clk) mem_din <= mem_rd ? mem_model(mem_a) : 8'hEE;

  task automatic applyStimulus(input logic [31:0] p, input logic hold, input logic br,
                               input logic busy);
    pc            = p;
    stall         = {4'b0, hold, 1'b0};
    branch_enable = br;
    mem_busy      = busy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_word(input logic [31:0] addr, input int exp_stalls, input int busy_start,
                            input int busy_len, input logic hold);
    int   stalls;
    bit   done;
    exp_t e;
    stalls = 0;
    done   = 0;
    addr_q.delete();
    if (exp_stalls > 0) for (int k = 0; k < 4; k++) addr_q.push_back(addr + 32'(k));
    if (!hold) begin
      e.pc   = addr;
      e.word = ref_word(addr);
      exp_q.push_back(e);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      applyStimulus(addr, hold, 1'b0, (c >= busy_start) && (c < busy_start + busy_len));
      #1;
      if (mem_rd) begin
        if (addr_q.size() == 0) checkOutput("unexpected_mem_rd", {31'b0, mem_rd}, 32'd0);
        else checkOutput("mem_a", mem_a, addr_q.pop_front());
      end
      if (c == 1 && !hold) checkOutput("bubble_valid", {31'b0, inst_valid}, 32'd0);
      if (stallreq_if) stalls++;
      else done = 1;
      tick();
    end
    if (!done) checkOutput("fetch_timeout", 32'd0, 32'd1);
    checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
    checkOutput("addr_q_drained", 32'(addr_q.size()), 32'd0);
    if (hold) begin
      checkOutput("hold_inst", inst, last_inst);
      checkOutput("hold_pc", inst_pc, last_pc);
      checkOutput("hold_valid", {31'b0, inst_valid}, {31'b0, last_valid});
    end else if (inst_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("inst", inst, e.word);
      checkOutput("inst_pc", inst_pc, e.pc);
      last_inst  = e.word;
      last_pc    = e.pc;
      last_valid = 1'b1;
    end else begin
      checkOutput("inst_valid", {31'b0, inst_valid}, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    last_inst  = NOP_W;
    last_pc    = '0;
    last_valid = 1'b0;
    rst        = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);

    tick();
    tick();
    checkOutput("rst_inst", inst, NOP_W);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_stallreq", {31'b0, stallreq_if}, 32'd0);
    rst = 1'b0;

    // Cold miss, then the same pc hits.
    fetch_word(32'h0000_0000, 5, 99, 0, 1'b0);
    checkOutput("boot_word", inst, 32'h00100093);
    fetch_word(32'h0000_0000, 0, 99, 0, 1'b0);

    // Memory contention for two cycles right after the first issue.
    fetch_word(32'h0000_0010, 7, 1, 2, 1'b0);

    // IF/ID held across DONE; the fill still lands in the cache.
    fetch_word(32'h0000_0030, 5, 99, 0, 1'b1);
    fetch_word(32'h0000_0030, 0, 99, 0, 1'b0);

    // Redirect while two bytes of 0x20 have arrived.
    applyStimulus(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("br_first_a", mem_a, 32'h20);
    tick();
    tick();
    tick();
    applyStimulus(32'h0000_0020, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("br_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("br_inst", inst, NOP_W);
    checkOutput("br_inst_pc", inst_pc, 32'd0);
    applyStimulus(32'h0000_0100, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("br_new_a", mem_a, 32'h100);
    checkOutput("br_new_rd", {31'b0, mem_rd}, 32'd1);

    // 0x100 aliases 0x000; the fill evicts it. 0x20 was never written.
    fetch_word(32'h0000_0100, 5, 99, 0, 1'b0);
    fetch_word(32'h0000_0000, 5, 99, 0, 1'b0);
    fetch_word(32'h0000_0020, 5, 99, 0, 1'b0);

    // Reset in the middle of a refill.
    applyStimulus(32'h0000_0040, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_mem_rd", {31'b0, mem_rd}, 32'd0);
    checkOutput("midrst_mem_a", mem_a, 32'd0);
    checkOutput("midrst_stallreq", {31'b0, stallreq_if}, 32'd0);
    tick();
    checkOutput("midrst_inst", inst, NOP_W);
    checkOutput("midrst_inst_pc", inst_pc, 32'd0);
    checkOutput("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    rst = 1'b0;

    // Cache contents are gone after reset.
    fetch_word(32'h0000_0010, 5, 99, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage directly downstream of the PC register. It takes the current `pc`, looks it up in a direct-mapped instruction cache, and on a miss fetches the 4 instruction bytes over the byte-wide memory port. It requests a pipeline stall while a fetch is outstanding and drives the registered IF/ID boundary (`inst`, `inst_pc`, `inst_valid`) consumed by decode.

## Interface
- `ICACHE_IDX_W`, default 6: cache index width; 2^ICACHE_IDX_W one-word entries.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc`  in  32  fetch address from the PC register; word-aligned.
- `stall`  in  6  pipeline stall vector; bit 1 holds the IF/ID outputs.
- `branch_enable`  in  1  redirect/flush; same signal the PC register consumes.
- `mem_busy`  in  1  data side owns the memory port this cycle; fetch must not issue.
- `mem_din`  in  8  read byte; valid one cycle after its address was issued.
- `mem_a`  out  32  byte address to memory.
- `mem_rd`  out  1  read strobe; `mem_a` is meaningful only when high.
- `stallreq_if`  out  1  fetch not ready; the controller uses it to hold `pc`.
- `inst`  out  32  fetched instruction (IF/ID).
- `inst_pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst` is a real instruction, not a bubble.

## Operation
- FSM states: IDLE, FETCH, DONE. Byte counters: `issued` (0..4) and `recv` (0..4).
- IDLE, cache hit (entry valid and tag equals `pc[31:ICACHE_IDX_W+2]`): `stallreq_if`=0, the instruction comes from the cache, and no memory access occurs.
- IDLE, miss: issue `mem_a`=pc and `mem_rd`=1 in the same cycle, then go to FETCH with `issued`=1.
- FETCH: each cycle with `mem_busy`=0 and `issued`<4 issues `mem_a`=pc+issued.
- A byte is captured whenever a read was issued in the previous cycle. Byte k lands in `buf[8k+7:8k]` (little-endian).
- When `recv` reaches 4, go to DONE.
- DONE: the assembled word is ready and `stallreq_if`=0. At the closing edge the word is written to the cache (valid bit set, tag written), and the FSM returns to IDLE.
- `stallreq_if`=1 in IDLE-miss and in FETCH; 0 otherwise.
- `mem_busy` during FETCH pauses issue. A byte whose address was issued in the previous cycle is still captured.
- IF/ID update, each edge, in priority order:
  - `rst` or `branch_enable`: `inst_valid`=0, `inst`=32'h00000013 (NOP), `inst_pc`=0.
  - Else `stall[1]`=1: hold all three outputs.
  - Else ready (hit or DONE): load the word and `pc`, and set `inst_valid`=1.
  - Else: `inst_valid`=0 and `inst`=NOP (bubble).
- `branch_enable` during FETCH or DONE: abort and return to IDLE. No cache write. The partial word is discarded, and any byte returning in the next cycle is ignored. Fetch restarts from the new `pc` the following cycle.
- Address arithmetic: pc+k is 32-bit with wrap-around at 0xFFFFFFFC+3.

## Timing
- Reset values:
  - FSM=IDLE, counters=0, all cache valid bits=0.
  - `mem_rd`=0, `mem_a`=0, `stallreq_if`=0 (while `rst` high).
  - `inst`=NOP, `inst_pc`=0, `inst_valid`=0.
- Hit: zero stall; the instruction appears at IF/ID on the next edge.
- Miss with no contention: address issued in cycles 0–3, bytes captured at the ends of cycles 1–4, and DONE in cycle 5. `stallreq_if` is high for cycles 0–4 (5 cycles). IF/ID and the cache are written at the end of cycle 5.
- Each `mem_busy` cycle during issue adds one cycle of penalty.
- `mem_a` and `mem_rd` are combinational from state, counters and `pc`. There is no combinational path from `mem_din` to any output.
- `rst` asserted mid-fetch: everything returns to reset values at that edge. An in-flight byte is ignored.

## Structure
- The shared defines header holds `NOP` (32'h00000013), the memory data width (8), and the stall bit positions.
- Sub-module `inst_cache`:
  - Parameter `ICACHE_IDX_W`.
  - Combinational read: `hit`, `rdata`.
  - Synchronous write: `we`, `waddr`, `wdata`.
  - Synchronous valid-bit clear on `rst`.
- `inst_fetch` owns the FSM, counters, byte buffer and IF/ID registers.

## Test plan
- Cold miss at pc=0x0000 with memory bytes 0x93,0x00,0x10,0x00: `mem_a` sequence 0,1,2,3; `stallreq_if` high 5 cycles; then `inst`=0x00100093, `inst_pc`=0, `inst_valid`=1.
- Refetch pc=0x0000 after the fill: hit, `mem_rd` stays 0, `stallreq_if`=0, same `inst` next edge.
- `mem_busy` high for 2 cycles after the first issue of pc=0x0010: the bytes are still assembled correctly, and `stallreq_if` is high 7 cycles.
- `branch_enable` with `branch_addr`=0x0100 while `recv`=2 on pc=0x0020: `inst_valid`=0; no cache write for 0x0020 (a later fetch of 0x0020 misses); next `mem_a`=0x0100.
- `stall[1]`=1 held across a DONE cycle: IF/ID outputs are unchanged.
- Alias check: pc=0x0000 and pc=0x0100 with ICACHE_IDX_W=6 map to the same entry. Filling 0x0100 evicts 0x0000, so a refetch of 0x0000 misses.
- Assert `rst` mid-fetch: reset values follow at the next edge.
